// File: rtl/clock_monitor.sv
// -----------------------------------------------------------------------------
// clock_monitor
//   Health monitor for a buffered clock. The monitored clock is treated as
//   asynchronous data: it is synchronized into the clk domain, its rising
//   edges are detected, and the spacing between edges (period) and the number
//   of cycles it was high in that spacing (high_time) are measured in clk
//   cycles. Periods outside [MIN_PERIOD, MAX_PERIOD] are flagged through
//   in_range, and a clock with no rising edge for TIMEOUT cycles is reported
//   as lost.
//
// Parameters
//   CNT_W      width of the period, high-time and timeout counters
//   MIN_PERIOD smallest in-range period (clk cycles)
//   MAX_PERIOD largest in-range period (clk cycles)
//   TIMEOUT    cycles without a rising edge before clk_lost asserts
//              (MIN_PERIOD <= MAX_PERIOD < TIMEOUT < 2**CNT_W)
//
// Ports
//   clk        in   system clock, all logic on its rising edge
//   rst        in   synchronous reset, active high
//   mon_clk    in   monitored clock, asynchronous to clk
//   period     out  last measured period in clk cycles
//   high_time  out  clk cycles the synchronized input was high in that period
//   meas_valid out  one-cycle pulse when period/high_time update
//   in_range   out  1 when MIN_PERIOD <= period <= MAX_PERIOD
//   clk_lost   out  1 while the monitored clock is considered stopped
//   state      out  FSM state: 0 IDLE, 1 MEASURE, 2 LOCKED, 3 LOST
// -----------------------------------------------------------------------------
module clock_monitor #(
  parameter int CNT_W      = 16,
  parameter int MIN_PERIOD = 4,
  parameter int MAX_PERIOD = 64,
  parameter int TIMEOUT    = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             in_range,
  output logic             clk_lost,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_P   = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           st;
  logic             s1, s2, s3;
  logic             rise;
  logic             timed_out;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] s2_ext;

  // Cycle counter saturates at TIMEOUT so a stopped clock parks the counter
  // at the timeout value instead of wrapping back into a legal period.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TMO) ? TMO : v + CNT_ONE;
  endfunction

  function automatic logic in_window(input logic [CNT_W-1:0] v);
    return (v >= MIN_P) && (v <= MAX_P);
  endfunction

  // s3 is only an edge-history flop; s1/s2 form the metastability chain.
  assign rise      = s2 & ~s3;
  assign timed_out = (cnt == TMO);
  assign s2_ext    = {{(CNT_W-1){1'b0}}, s2};
  assign state     = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      cnt        <= '0;
      hcnt       <= '0;
      st         <= IDLE;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      in_range   <= 1'b0;
      clk_lost   <= 1'b0;
    end else begin
      // Synchronizer and edge history
      s1 <= mon_clk;
      s2 <= s1;
      s3 <= s2;

      // Counters restart at 1 on a rise so the value seen at the next rise is
      // exactly the number of clk cycles between the two rises.
      cnt  <= rise ? CNT_ONE : sat_inc(cnt);
      hcnt <= rise ? CNT_ONE : hcnt + s2_ext;

      meas_valid <= 1'b0;

      // Edge/timeout FSM; a rise wins over a timeout in the same cycle
      case (st)
        IDLE: begin
          if (rise) begin
            st <= MEASURE;
          end else if (timed_out) begin
            st       <= LOST;
            clk_lost <= 1'b1;
            in_range <= 1'b0;
          end
        end
        MEASURE, LOCKED: begin
          if (rise) begin
            st         <= LOCKED;
            period     <= cnt;
            high_time  <= hcnt;
            meas_valid <= 1'b1;
            in_range   <= in_window(cnt);
          end else if (timed_out) begin
            st       <= LOST;
            clk_lost <= 1'b1;
            in_range <= 1'b0;
          end
        end
        LOST: begin
          // Recovery only re-arms measurement; the interval back to the last
          // edge before the loss is meaningless and is not captured.
          if (rise) begin
            st       <= MEASURE;
            clk_lost <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
